// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator for the photo-frame display path.
//   It produces the sync, data-enable and image-window signals with
//   configurable sync polarity and 1x/2x/4x pixel replication. It also issues
//   one SPRAM line-read request per source row, one line ahead of display.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   synchronous reset, active low
//   state        in   system state (3 = display; anything else holds idle)
//   x_counter    out  horizontal counter, 0..H_TOTAL-1
//   y_counter    out  vertical counter, 0..V_TOTAL-1
//   xpos / ypos  out  counters relative to the active-area origin (comb)
//   vga_hs/vs    out  registered syncs, polarity set by HS_POL / VS_POL
//   de           out  registered active-area enable
//   img_active   out  registered "inside the scaled image window"
//   img_x/img_y  out  source pixel coordinates, valid with img_active
//   frame_start  out  one-cycle pulse for counter (0,0)
//   line_rd_req  out  one-cycle SPRAM line-read request
//   line_rd_row  out  source row of the last request
module vga_timing_gen #(
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int H_DISP     = 800,
    parameter int H_FRONT    = 56,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter int V_DISP     = 600,
    parameter int V_FRONT    = 37,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int IMG_W      = 200,
    parameter int IMG_H      = 150,
    parameter int START_COL  = 0,
    parameter int START_ROW  = 0,
    parameter int SCALE_LOG2 = 0,
    parameter int CW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    state,
    output logic [CW-1:0] x_counter,
    output logic [CW-1:0] y_counter,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          de,
    output logic          img_active,
    output logic [CW-1:0] img_x,
    output logic [CW-1:0] img_y,
    output logic          frame_start,
    output logic          line_rd_req,
    output logic [CW-1:0] line_rd_row
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int DW      = IMG_W << SCALE_LOG2;
    localparam int DH      = IMG_H << SCALE_LOG2;

    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C    = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C    = CW'(V_SYNC);
    localparam logic [CW-1:0] H_START_C   = CW'(H_START);
    localparam logic [CW-1:0] V_START_C   = CW'(V_START);
    localparam logic [CW-1:0] H_END_C     = CW'(H_START + H_DISP);
    localparam logic [CW-1:0] V_END_C     = CW'(V_START + V_DISP);
    localparam logic [CW-1:0] START_COL_C = CW'(START_COL);
    localparam logic [CW-1:0] START_ROW_C = CW'(START_ROW);
    localparam logic [CW-1:0] ROW0_C      = CW'(V_START + START_ROW);
    localparam logic [CW-1:0] DW_C        = CW'(DW);
    localparam logic [CW-1:0] DH_C        = CW'(DH);
    localparam logic [CW-1:0] SMASK       = CW'((1 << SCALE_LOG2) - 1);

    // Inactive sync level: high for active-low syncs, low for active-high.
    localparam logic HS_IDLE = (HS_POL == 0) ? 1'b1 : 1'b0;
    localparam logic VS_IDLE = (VS_POL == 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          de_q, de_d, ia_q, ia_d;
    logic [CW-1:0] ix_q, ix_d, iy_q, iy_d;
    logic          fs_q, fs_d, req_q, req_d;
    logic [CW-1:0] row_q, row_d;

    logic          run;
    logic          x_wrap, y_wrap;
    logic [CW-1:0] col_off, row_off, r_next;

    assign run    = (state == 8'd3);
    assign x_wrap = (x_q == H_LAST);
    assign y_wrap = (y_q == V_LAST);

    assign xpos    = x_q - H_START_C;
    assign ypos    = y_q - V_START_C;
    assign col_off = xpos - START_COL_C;
    assign row_off = ypos - START_ROW_C;

    // Window-relative index of the line that follows the current one; values
    // above the window wrap to large unsigned numbers and fail the DH compare.
    assign r_next  = y_q + 1'b1 - ROW0_C;

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (run) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            y_d = y_q;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + 1'b1;
            end
        end
    end

    always_comb begin
        hs_d  = HS_IDLE;
        vs_d  = VS_IDLE;
        de_d  = 1'b0;
        ia_d  = 1'b0;
        ix_d  = '0;
        iy_d  = '0;
        fs_d  = 1'b0;
        req_d = 1'b0;
        row_d = '0;
        if (run) begin
            hs_d  = (x_q < H_SYNC_C) ^ HS_IDLE;
            vs_d  = (y_q < V_SYNC_C) ^ VS_IDLE;
            de_d  = (x_q >= H_START_C) && (x_q < H_END_C) &&
                    (y_q >= V_START_C) && (y_q < V_END_C);
            ia_d  = de_d && (col_off < DW_C) && (row_off < DH_C);
            ix_d  = col_off >> SCALE_LOG2;
            iy_d  = row_off >> SCALE_LOG2;
            fs_d  = (x_q == '0) && (y_q == '0);
            // The last line is excluded so the frame wrap never fetches.
            req_d = (x_q == H_END_C) && !y_wrap && (r_next < DH_C) &&
                    ((r_next & SMASK) == '0);
            row_d = req_d ? (r_next >> SCALE_LOG2) : row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= HS_IDLE;
            vs_q  <= VS_IDLE;
            de_q  <= 1'b0;
            ia_q  <= 1'b0;
            ix_q  <= '0;
            iy_q  <= '0;
            fs_q  <= 1'b0;
            req_q <= 1'b0;
            row_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            ia_q  <= ia_d;
            ix_q  <= ix_d;
            iy_q  <= iy_d;
            fs_q  <= fs_d;
            req_q <= req_d;
            row_q <= row_d;
        end
    end

    assign x_counter   = x_q;
    assign y_counter   = y_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign de          = de_q;
    assign img_active  = ia_q;
    assign img_x       = ix_q;
    assign img_y       = iy_q;
    assign frame_start = fs_q;
    assign line_rd_req = req_q;
    assign line_rd_row = row_q;

endmodule
